bsg_cache_to_dram_ctrl_rx: RTL and testbench
============================================

# bsg_cache_to_dram_ctrl_rx

Read-return stage between the DRAM controller read-data port (app_rd_data_*) and the per-DMA-engine data inputs of the cache DMA interfaces; it is the receive counterpart of the tx write path. The DRAM controller cannot be back-pressured on read data, so this block buffers returning bursts, tracks which DMA engine owns each outstanding read, and throttles read-command issue with a burst credit counter. It delivers each burst, in command order, to the DMA engine that requested it.

## Interface
- num_dma_p, 4, number of DMA engines; tag width lg_num_dma = max(1, clog2(num_dma_p))
- dma_data_width_p, 32, word width on both sides
- dram_ctrl_burst_len_p, 8, words per DRAM read burst; must equal the DMA burst length
- data_els_p, 16, data buffer depth in words; must be a multiple of dram_ctrl_burst_len_p and at least dram_ctrl_burst_len_p
- tag_els_p, 4, maximum number of outstanding read bursts

- clk_i  in  1  clock; single clock domain
- reset_i  in  1  synchronous, active-high reset
- read_v_i  in  1  read command issued to the DRAM controller this cycle
- read_tag_i  in  lg_num_dma  DMA engine that owns the command
- read_ready_o  out  1  a read command may be issued
- app_rd_data_valid_i  in  1  read-data word valid
- app_rd_data_i  in  dma_data_width_p  read-data word
- app_rd_data_end_i  in  1  last word of the burst
- dma_data_o  out  dma_data_width_p  head word, broadcast to all engines
- dma_data_v_o  out  num_dma_p  one-hot valid, per engine
- dma_data_ready_i  in  num_dma_p  per-engine ready
- error_o  out  1  sticky protocol error (see Configuration)

## Operation
- Credit counter, width clog2(data_els_p/burst+1):
  - Resets to data_els_p/dram_ctrl_burst_len_p.
  - Decrements on a read command accept (read_v_i & read_ready_o).
  - Increments when the last word of a burst is dequeued.
  - An accept and a last-word dequeue in the same cycle leave the counter unchanged.
- read_ready_o = (credits != 0) & ~tag_fifo_full. A read_v_i while read_ready_o=0 is ignored and no tag is pushed.
- Tag FIFO (tag_els_p): pushes read_tag_i on each accept; pops on the last-word dequeue.
- Data FIFO (data_els_p): pushes app_rd_data_i on every app_rd_data_valid_i, unconditionally. The credit scheme guarantees it never overflows.
- Output word counter, 0..dram_ctrl_burst_len_p-1:
  - Increments on each dequeue and wraps to 0 after burst_len-1.
  - That wrap is the last-word event.
- Valid and dequeue:
  - dma_data_v_o[t] = data_fifo_valid & tag_fifo_valid & (head_tag == t); all other bits are 0.
  - Dequeue = dma_data_v_o[head_tag] & dma_data_ready_i[head_tag]. Ready bits of non-selected engines are ignored.
- Bursts are delivered strictly in command order. A burst is never interleaved with another.
- app_rd_data_end_i is not used for framing; the output word counter alone frames bursts.

## Timing
- Reset values: read_ready_o=0 while reset_i is high and 1 on the first cycle after it; dma_data_v_o=0; error_o=0.
- Reset clears all FIFO pointers and counters and restores credits. Data and tags in flight at reset are discarded.
- Latency: a word accepted at cycle n is visible on dma_data_o/dma_data_v_o at cycle n+1 at the earliest. There is no combinational path from app_rd_data_* to the outputs.
- dma_data_o is valid only while some dma_data_v_o bit is 1. Its value otherwise is don't-care.
- read_ready_o depends only on registered state; it has no combinational path from read_v_i.
- Throughput: one word per cycle in and one word per cycle out, sustained with both happening in the same cycle.
- A credit returned by a last-word dequeue at cycle n raises read_ready_o at cycle n+1.

## Configuration
- BSG_CACHE_TO_DRAM_CTRL_RX_CHECK_EN defined: error_o is set (sticky until reset) on any of:
  - app_rd_data_valid_i while the data FIFO is full;
  - app_rd_data_valid_i with no outstanding command, tracked by an input-side word counter against the tag count;
  - app_rd_data_end_i not equal to (input word counter == burst_len-1) on a valid word.
- Not defined: error_o is tied to 0 and no checker logic is built.

## Structure
- Package bsg_cache_to_dram_ctrl_pkg holds the derived-width constants (lg_num_dma, credit width, word-counter width) shared with the tx side.
- Sub-module: bsg_fifo_1r1w_small, instantiated twice:
  - data FIFO, dma_data_width_p x data_els_p;
  - tag FIFO, lg_num_dma x tag_els_p.
- Credit counter, output word counter, tag decode and checker are local logic.

## Test plan
- Reset → read_ready_o=0 during reset, 1 on the next cycle; dma_data_v_o=4'b0000; error_o=0.
- Issue one read with tag 2, return 8 words 0x10..0x17, hold dma_data_ready_i=4'b0100 → dma_data_v_o=4'b0100 for 8 consecutive cycles with data 0x10..0x17 in order, then 0; credits return to 2.
- Issue two reads back-to-back (tags 1, 3) with default params, third read_v_i → read_ready_o=0 after the second accept; no third tag pushed; both bursts delivered 1 then 3; read_ready_o=1 the cycle after the first burst's 8th dequeue.
- Output stall: tag 0 burst arrives while dma_data_ready_i=0 for 20 cycles → all 8 words retained; on ready, delivered without loss; ready on engine 1 during the stall has no effect.
- Simultaneous accept and last-word dequeue → credits unchanged; read_ready_o stays 1.
- With CHECK_EN: drive app_rd_data_valid_i with no command outstanding → error_o=1 next cycle and stays 1 until reset_i. Without CHECK_EN the same stimulus leaves error_o=0.

Source files
------------

// File: rtl/bsg_cache_to_dram_ctrl_pkg.sv
// Derived-width helpers shared by the cache-to-DRAM-controller rx and tx paths.
// Every width is computed from the block parameters, so both sides stay consistent.
package bsg_cache_to_dram_ctrl_pkg;

    // Width of a DMA engine tag. It is never narrower than one bit.
    function automatic int lg_num_dma_f(input int num_dma);
        return (num_dma <= 2) ? 1 : $clog2(num_dma);
    endfunction

    // Width of the burst credit counter. It holds values 0..data_els/burst.
    function automatic int credit_width_f(input int data_els, input int burst_len);
        return $clog2(data_els / burst_len + 1);
    endfunction

    // Width of a word-within-burst counter. It holds values 0..burst_len-1.
    function automatic int word_cnt_width_f(input int burst_len);
        return (burst_len <= 2) ? 1 : $clog2(burst_len);
    endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small one-read/one-write FIFO built on a register array with a valid/yumi output handshake.
// The head entry is read from registered storage, so no input reaches data_o combinationally.
module bsg_fifo_1r1w_small #(
    parameter int width_p = 8,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);
    localparam int ptr_w = (els_p <= 2) ? 1 : $clog2(els_p);
    localparam int cnt_w = $clog2(els_p + 1);

    logic [width_p-1:0] mem_q [els_p];
    logic [ptr_w-1:0]   wptr_q, rptr_q;
    logic [cnt_w-1:0]   count_q, count_d;
    logic               push, pop;

    function automatic logic [ptr_w-1:0] next_ptr(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign ready_o = (count_q != cnt_w'(els_p));
    assign v_o     = (count_q != '0);
    assign data_o  = mem_q[rptr_q];
    assign push    = v_i & ready_o;
    assign pop     = yumi_i & v_o;

    // Occupancy follows pushes and pops. A simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count state. Reset discards all stored entries.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= next_ptr(wptr_q);
            if (pop)  rptr_q <= next_ptr(rptr_q);
            count_q <= count_d;
        end
    end

    // Storage write. The array is deliberately left unreset.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/bsg_cache_to_dram_ctrl_rx.sv
// Read-return stage: buffers DRAM read bursts and hands each burst, in command order, to the
// DMA engine that issued it. A burst credit counter throttles read-command issue.
// Optional protocol checker: define BSG_CACHE_TO_DRAM_CTRL_RX_CHECK_EN to build it.
// Without it, error_o is tied low.
module bsg_cache_to_dram_ctrl_rx
    import bsg_cache_to_dram_ctrl_pkg::*;
#(
    parameter int num_dma_p             = 4,
    parameter int dma_data_width_p      = 32,
    parameter int dram_ctrl_burst_len_p = 8,
    parameter int data_els_p            = 16,
    parameter int tag_els_p             = 4
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic                                   read_v_i,
    input  logic [lg_num_dma_f(num_dma_p)-1:0]     read_tag_i,
    output logic                                   read_ready_o,
    input  logic                                   app_rd_data_valid_i,
    input  logic [dma_data_width_p-1:0]            app_rd_data_i,
    input  logic                                   app_rd_data_end_i,
    output logic [dma_data_width_p-1:0]            dma_data_o,
    output logic [num_dma_p-1:0]                   dma_data_v_o,
    input  logic [num_dma_p-1:0]                   dma_data_ready_i,
    output logic                                   error_o
);
    localparam int lg_w       = lg_num_dma_f(num_dma_p);
    localparam int cred_w     = credit_width_f(data_els_p, dram_ctrl_burst_len_p);
    localparam int wc_w       = word_cnt_width_f(dram_ctrl_burst_len_p);
    localparam int credit_max = data_els_p / dram_ctrl_burst_len_p;

    logic [cred_w-1:0] credits_q, credits_d;
    logic [wc_w-1:0]   word_cnt_q;
    logic              data_ready, data_v, tag_ready, tag_v;
    logic [lg_w-1:0]   head_tag;
    logic              accept, deq, last_deq;

    assign read_ready_o = ~reset_i & (credits_q != '0) & tag_ready;
    assign accept       = read_v_i & read_ready_o;
    assign dma_data_v_o = (data_v & tag_v) ? (num_dma_p'(1) << head_tag) : '0;
    assign deq          = |(dma_data_v_o & dma_data_ready_i);
    assign last_deq     = deq & (word_cnt_q == wc_w'(dram_ctrl_burst_len_p - 1));

    bsg_fifo_1r1w_small #(.width_p(dma_data_width_p), .els_p(data_els_p)) data_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (app_rd_data_valid_i),
        .data_i  (app_rd_data_i),
        .ready_o (data_ready),
        .v_o     (data_v),
        .data_o  (dma_data_o),
        .yumi_i  (deq)
    );

    bsg_fifo_1r1w_small #(.width_p(lg_w), .els_p(tag_els_p)) tag_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (accept),
        .data_i  (read_tag_i),
        .ready_o (tag_ready),
        .v_o     (tag_v),
        .data_o  (head_tag),
        .yumi_i  (last_deq)
    );

    // Credits: an accept spends one and a completed burst returns one. Both at once cancel.
    always_comb begin
        credits_d = credits_q;
        case ({accept, last_deq})
            2'b10:   credits_d = credits_q - 1'b1;
            2'b01:   credits_d = credits_q + 1'b1;
            default: credits_d = credits_q;
        endcase
    end

    // Credit and output word-counter state. The word counter alone frames outgoing bursts.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            credits_q  <= cred_w'(credit_max);
            word_cnt_q <= '0;
        end else begin
            credits_q <= credits_d;
            if (deq) word_cnt_q <= last_deq ? '0 : word_cnt_q + 1'b1;
        end
    end

`ifdef BSG_CACHE_TO_DRAM_CTRL_RX_CHECK_EN
    localparam int pend_w = $clog2(tag_els_p + 1);

    logic [wc_w-1:0]   in_cnt_q;
    logic [pend_w-1:0] pend_q;
    logic              err_q;
    logic              in_last;

    assign in_last = app_rd_data_valid_i & (in_cnt_q == wc_w'(dram_ctrl_burst_len_p - 1));
    assign error_o = err_q;

    // Input-side framing. pend_q counts commands whose data has not fully arrived yet.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            in_cnt_q <= '0;
            pend_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            if (app_rd_data_valid_i) in_cnt_q <= in_last ? '0 : in_cnt_q + 1'b1;
            if (accept && !(in_last && pend_q != '0)) pend_q <= pend_q + 1'b1;
            else if (!accept && in_last && pend_q != '0) pend_q <= pend_q - 1'b1;
            if (app_rd_data_valid_i &&
                (!data_ready || pend_q == '0 || (app_rd_data_end_i != in_last)))
                err_q <= 1'b1;
        end
    end
`else
    logic unused_chk;
    assign unused_chk = ^{app_rd_data_end_i, data_ready};
    assign error_o    = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_cache_to_dram_ctrl_rx.sv
// Directed bench for bsg_cache_to_dram_ctrl_rx with default parameters.
module tb_bsg_cache_to_dram_ctrl_rx;
    logic        clk = 1'b0;
    logic        reset_i;
    logic        read_v_i;
    logic [1:0]  read_tag_i;
    logic        read_ready_o;
    logic        app_rd_data_valid_i;
    logic [31:0] app_rd_data_i;
    logic        app_rd_data_end_i;
    logic [31:0] dma_data_o;
    logic [3:0]  dma_data_v_o;
    logic [3:0]  dma_data_ready_i;
    logic        error_o;

    int n_tests = 0;
    int n_fail  = 0;

    bsg_cache_to_dram_ctrl_rx dut (
        .clk_i               (clk),
        .reset_i             (reset_i),
        .read_v_i            (read_v_i),
        .read_tag_i          (read_tag_i),
        .read_ready_o        (read_ready_o),
        .app_rd_data_valid_i (app_rd_data_valid_i),
        .app_rd_data_i       (app_rd_data_i),
        .app_rd_data_end_i   (app_rd_data_end_i),
        .dma_data_o          (dma_data_o),
        .dma_data_v_o        (dma_data_v_o),
        .dma_data_ready_i    (dma_data_ready_i),
        .error_o             (error_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one read command; it must be accepted in this cycle.
    task automatic issue(input logic [1:0] tag);
        read_v_i   = 1'b1;
        read_tag_i = tag;
        @(negedge clk);
        chk("issue_ready", {31'd0, read_ready_o}, 32'd1);
        tick();
        read_v_i = 1'b0;
    endtask

    // Return nb bursts of words base.., one per cycle, and check in-order delivery one cycle later.
    // With chk_rdy set, read_ready_o must be 0 until the cycle after the first burst's 8th dequeue.
    task automatic stream(input logic [31:0] base, input int nb, input logic [1:0] t0,
                          input logic [1:0] t1, input bit chk_rdy);
        for (int i = 0; i <= nb * 8; i++) begin
            app_rd_data_valid_i = (i < nb * 8);
            app_rd_data_i       = base + 32'(i);
            app_rd_data_end_i   = (i % 8 == 7);
            @(negedge clk);
            if (i >= 1) begin
                chk("stream_v", {28'd0, dma_data_v_o}, {28'd0, 4'b0001 << (((i - 1) < 8) ? t0 : t1)});
                chk("stream_data", dma_data_o, base + 32'(i - 1));
            end
            if (chk_rdy) chk("stream_ready", {31'd0, read_ready_o}, (i >= 9) ? 32'd1 : 32'd0);
            tick();
        end
        app_rd_data_valid_i = 1'b0;
        app_rd_data_end_i   = 1'b0;
        @(negedge clk);
        chk("stream_idle_v", {28'd0, dma_data_v_o}, 32'd0);
        tick();
    endtask

    initial begin
        reset_i             = 1'b1;
        read_v_i            = 1'b0;
        read_tag_i          = 2'd0;
        app_rd_data_valid_i = 1'b0;
        app_rd_data_i       = '0;
        app_rd_data_end_i   = 1'b0;
        dma_data_ready_i    = 4'b0000;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        chk("rst_ready", {31'd0, read_ready_o}, 32'd0);
        chk("rst_v", {28'd0, dma_data_v_o}, 32'd0);
        chk("rst_err", {31'd0, error_o}, 32'd0);
        tick();
        reset_i = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, read_ready_o}, 32'd1);
        tick();

        // Single burst to engine 2
        dma_data_ready_i = 4'b0100;
        issue(2'd2);
        stream(32'h10, 1, 2'd2, 2'd2, 1'b0);

        // Two bursts back to back; a third command is refused
        dma_data_ready_i = 4'b1010;
        issue(2'd1);
        issue(2'd3);
        read_v_i   = 1'b1;
        read_tag_i = 2'd0;
        @(negedge clk);
        chk("third_refused", {31'd0, read_ready_o}, 32'd0);
        tick();
        read_v_i = 1'b0;
        stream(32'h20, 2, 2'd1, 2'd3, 1'b1);

        // Accept and last-word dequeue in the same cycle keep credits unchanged
        dma_data_ready_i = 4'b0100;
        issue(2'd2);
        for (int i = 0; i <= 8; i++) begin
            app_rd_data_valid_i = (i < 8);
            app_rd_data_i       = 32'h40 + 32'(i);
            app_rd_data_end_i   = (i == 7);
            read_v_i            = (i == 8);
            read_tag_i          = 2'd3;
            @(negedge clk);
            if (i == 8) begin
                chk("simul_v", {28'd0, dma_data_v_o}, 32'h4);
                chk("simul_data", dma_data_o, 32'h47);
                chk("simul_ready", {31'd0, read_ready_o}, 32'd1);
            end
            tick();
        end
        read_v_i            = 1'b0;
        app_rd_data_valid_i = 1'b0;
        app_rd_data_end_i   = 1'b0;
        @(negedge clk);
        chk("simul_after_ready", {31'd0, read_ready_o}, 32'd1);
        tick();
        issue(2'd1);
        @(negedge clk);
        chk("credits_exhausted", {31'd0, read_ready_o}, 32'd0);
        tick();
        dma_data_ready_i = 4'b1010;
        stream(32'h50, 2, 2'd3, 2'd1, 1'b1);

        // Output stall on engine 0 while engine 1 is ready
        dma_data_ready_i = 4'b0010;
        issue(2'd0);
        for (int i = 0; i < 20; i++) begin
            app_rd_data_valid_i = (i < 8);
            app_rd_data_i       = 32'h30 + 32'(i);
            app_rd_data_end_i   = (i == 7);
            @(negedge clk);
            if (i >= 1) begin
                chk("stall_v", {28'd0, dma_data_v_o}, 32'h1);
                chk("stall_data", dma_data_o, 32'h30);
            end
            tick();
        end
        app_rd_data_valid_i = 1'b0;
        app_rd_data_end_i   = 1'b0;
        dma_data_ready_i    = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("drain_v", {28'd0, dma_data_v_o}, 32'h1);
            chk("drain_data", dma_data_o, 32'h30 + 32'(k));
            tick();
        end
        @(negedge clk);
        chk("drain_idle_v", {28'd0, dma_data_v_o}, 32'd0);
        chk("drain_ready", {31'd0, read_ready_o}, 32'd1);
        tick();

        // Read data with no outstanding command
        app_rd_data_valid_i = 1'b1;
        app_rd_data_i       = 32'hDEAD;
        tick();
        app_rd_data_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
`ifdef BSG_CACHE_TO_DRAM_CTRL_RX_CHECK_EN
            chk("err_sticky", {31'd0, error_o}, 32'd1);
`else
            chk("err_tied", {31'd0, error_o}, 32'd0);
`endif
            chk("stray_no_v", {28'd0, dma_data_v_o}, 32'd0);
            tick();
        end

        // Reset discards the stray word and clears the error
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        @(negedge clk);
        chk("rst2_err", {31'd0, error_o}, 32'd0);
        chk("rst2_ready", {31'd0, read_ready_o}, 32'd1);
        tick();
        dma_data_ready_i = 4'b0001;
        issue(2'd0);
        stream(32'h60, 1, 2'd0, 2'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
